wb_cmd_initiator: RTL and testbench

- Wishbone pipelined-mode master (initiator); the other end of the bus from the team's peripheral responders (LED/button register blocks at 0x3000_0000 and up).
- Converts single commands from a valid/ready command port into one Wishbone transaction each, then returns read data or write completion on a valid/ready response port.
- Sits between a local controller (sequencer, UART bridge, test harness) and the user-area Wishbone bus.

---
 rtl/wb_pkg.sv | 33 +++
 rtl/wb_cmd_initiator_if.sv | 43 ++++
 rtl/wb_timeout_timer.sv | 38 +++
 rtl/wb_cmd_initiator.sv | 156 +++++++++++++++
 tb/tb_wb_cmd_initiator.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared Wishbone widths, initiator FSM states, request payload type
// and the responder addresses used on the user-area bus.
// Optional feature macro used by wb_cmd_initiator: WB_TIMEOUT_EN.
package wb_pkg;

    localparam int unsigned WB_ADDR_W = 32;
    localparam int unsigned WB_DATA_W = 32;
    localparam int unsigned WB_SEL_W  = 4;

    localparam logic [WB_ADDR_W-1:0] LED_ADDR    = 32'h3000_0000;
    localparam logic [WB_ADDR_W-1:0] BUTTON_ADDR = 32'h3000_0004;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RSP  = 2'd3
    } wb_state_e;

    // Request payload presented on the Wishbone master outputs.
    typedef struct packed {
        logic                 we;
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
        logic [WB_SEL_W-1:0]  sel;
    } wb_req_t;

    // Word accesses only: any nonzero low address bit is a misaligned command.
    function automatic logic addr_misaligned(input logic [WB_ADDR_W-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/wb_cmd_initiator_if.sv
// wb_cmd_initiator_if: command port, response port and Wishbone master bus of
// the command initiator.
//   master modport : the initiator (drives cmd_ready, rsp_*, o_wb_*)
//   slave modport  : the environment (controller + Wishbone responder)
interface wb_cmd_initiator_if;
    import wb_pkg::*;

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_we;
    logic [WB_ADDR_W-1:0] cmd_addr;
    logic [WB_DATA_W-1:0] cmd_data;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [WB_DATA_W-1:0] rsp_data;
    logic                 rsp_err;

    logic                 o_wb_cyc;
    logic                 o_wb_stb;
    logic                 o_wb_we;
    logic [WB_ADDR_W-1:0] o_wb_addr;
    logic [WB_DATA_W-1:0] o_wb_data;
    logic [WB_SEL_W-1:0]  o_wb_sel;
    logic                 i_wb_ack;
    logic                 i_wb_stall;
    logic [WB_DATA_W-1:0] i_wb_data;

    modport master (
        input  cmd_valid, cmd_we, cmd_addr, cmd_data, rsp_ready,
        input  i_wb_ack, i_wb_stall, i_wb_data,
        output cmd_ready, rsp_valid, rsp_data, rsp_err,
        output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_addr, cmd_data, rsp_ready,
        output i_wb_ack, i_wb_stall, i_wb_data,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err,
        input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel
    );

endinterface

// File: rtl/wb_timeout_timer.sv
// wb_timeout_timer: counts WAIT cycles and flags the cycle on which the count
// reaches TIMEOUT_CYCLES.
//   clk, reset : clock, async active-high reset
//   run        : 1 while the initiator is in WAIT; 0 clears the count
//   expired_c  : combinational, high on the TIMEOUT_CYCLES-th WAIT cycle
module wb_timeout_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic expired_c
);
    localparam int unsigned CNT_W = 16;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!run) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // cnt_q holds the number of WAIT cycles already completed.
    assign expired_c = run && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_cmd_initiator.sv
// wb_cmd_initiator: Wishbone pipelined-mode master. Each accepted command
// becomes one bus transaction; the result is returned on the response port.
//   clk, reset : clock, async active-high reset
//   bus        : wb_cmd_initiator_if.master (cmd_*, rsp_*, o_wb_*, i_wb_*)
// Parameters: ADDR_ALIGN_CHECK (reject misaligned commands),
//             TIMEOUT_CYCLES (WAIT abort limit, 1..65535).
// Optional macro WB_TIMEOUT_EN adds the WAIT timeout abort.
module wb_cmd_initiator
    import wb_pkg::*;
#(
    parameter bit          ADDR_ALIGN_CHECK = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES   = 16
) (
    input  logic                clk,
    input  logic                reset,
    wb_cmd_initiator_if.master  bus
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("wb_cmd_initiator: TIMEOUT_CYCLES out of range 1..65535");
    end

    wb_state_e            state_q, state_d;
    wb_req_t              req_q, req_d;
    logic                 cyc_q, cyc_d;
    logic                 stb_q, stb_d;
    logic                 cmd_ready_q, cmd_ready_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [WB_DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic                 rsp_err_q, rsp_err_d;
    logic                 done_c;
    logic                 abort_c;
    logic                 tmr_expired_c;

`ifdef WB_TIMEOUT_EN
    wb_timeout_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .run       (state_q == WAIT),
        .expired_c (tmr_expired_c)
    );
`else
    assign tmr_expired_c = 1'b0;
`endif

    // Next state and next register values.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        done_c      = 1'b0;
        abort_c     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    cmd_ready_d = 1'b0;
                    if (ADDR_ALIGN_CHECK && addr_misaligned(bus.cmd_addr)) begin
                        state_d     = RSP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = '0;
                    end else begin
                        state_d    = REQ;
                        cyc_d      = 1'b1;
                        stb_d      = 1'b1;
                        req_d.we   = bus.cmd_we;
                        req_d.addr = bus.cmd_addr;
                        req_d.data = bus.cmd_data;
                        req_d.sel  = '1;
                    end
                end
            end
            REQ: begin
                if (!bus.i_wb_stall) begin
                    stb_d = 1'b0;
                    // A combinational responder may ack the strobe it just took.
                    if (bus.i_wb_ack) begin
                        done_c = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                // Ack has priority over a timeout expiring in the same cycle.
                if (bus.i_wb_ack) begin
                    done_c = 1'b1;
                end else if (tmr_expired_c) begin
                    abort_c = 1'b1;
                end
            end
            RSP: begin
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Close the bus cycle and post the response.
        if (done_c || abort_c) begin
            state_d     = RSP;
            cyc_d       = 1'b0;
            stb_d       = 1'b0;
            req_d.we    = 1'b0;
            req_d.sel   = '0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = abort_c;
            rsp_data_d  = (abort_c || req_q.we) ? '0 : bus.i_wb_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            req_q       <= '0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.o_wb_cyc  = cyc_q;
    assign bus.o_wb_stb  = stb_q;
    assign bus.o_wb_we   = req_q.we;
    assign bus.o_wb_addr = req_q.addr;
    assign bus.o_wb_data = req_q.data;
    assign bus.o_wb_sel  = req_q.sel;

endmodule

// File: tb/tb_wb_cmd_initiator.sv
// tb_wb_cmd_initiator: directed bench for wb_cmd_initiator with a small
// Wishbone responder (LED register write capture, constant button read data).
// Timeout steps are included when WB_TIMEOUT_EN is defined.
module tb_wb_cmd_initiator;
    import wb_pkg::*;

    localparam int unsigned TB_TIMEOUT = 4;
    localparam logic [31:0] BTN_VAL    = 32'h0000_0005;

    logic clk = 1'b0;
    logic reset;

    wb_cmd_initiator_if bus ();

    wb_cmd_initiator #(
        .ADDR_ALIGN_CHECK (1'b1),
        .TIMEOUT_CYCLES   (TB_TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Responder: registered ack one cycle after a taken strobe, or a
    // combinational ack, or none; force_ack injects a raw ack pulse.
    logic        ack_r = 1'b0;
    logic        comb_mode = 1'b0;
    logic        noack_mode = 1'b0;
    logic        force_ack = 1'b0;
    logic [31:0] led_reg = 32'h0;
    int          strobes = 0;
    logic        taken;

    assign taken = bus.o_wb_cyc && bus.o_wb_stb && !bus.i_wb_stall;

    always @(posedge clk) begin
        ack_r <= taken && !comb_mode && !noack_mode;
        if (taken) begin
            strobes <= strobes + 1;
            if (bus.o_wb_we && bus.o_wb_addr == LED_ADDR) led_reg <= bus.o_wb_data;
        end
    end

    assign bus.i_wb_ack  = ack_r | force_ack | (comb_mode & taken);
    assign bus.i_wb_data = BTN_VAL;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] data);
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = we;
        bus.cmd_addr  = addr;
        bus.cmd_data  = data;
        step();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic handshake();
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        check("hs_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("hs_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0;
        reset          = 1'b1;
        bus.cmd_valid  = 1'b0;
        bus.cmd_we     = 1'b0;
        bus.cmd_addr   = '0;
        bus.cmd_data   = '0;
        bus.rsp_ready  = 1'b0;
        bus.i_wb_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_data",  bus.rsp_data,       32'd0);
        check("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
        check("rst_cyc",       32'(bus.o_wb_cyc),  32'd0);
        check("rst_stb",       32'(bus.o_wb_stb),  32'd0);
        check("rst_we",        32'(bus.o_wb_we),   32'd0);
        check("rst_addr",      bus.o_wb_addr,      32'd0);
        check("rst_sel",       32'(bus.o_wb_sel),  32'd0);
        reset = 1'b0;
        step();

        // Write LED, ack one cycle after strobe.
        send(1'b1, LED_ADDR, 32'h0000_00A5);
        check("wr_c1_cyc",  32'(bus.o_wb_cyc),  32'd1);
        check("wr_c1_stb",  32'(bus.o_wb_stb),  32'd1);
        check("wr_c1_we",   32'(bus.o_wb_we),   32'd1);
        check("wr_c1_sel",  32'(bus.o_wb_sel),  32'hF);
        check("wr_c1_addr", bus.o_wb_addr,      LED_ADDR);
        check("wr_c1_data", bus.o_wb_data,      32'h0000_00A5);
        check("wr_c1_rdy",  32'(bus.cmd_ready), 32'd0);
        step();
        check("wr_c2_stb",  32'(bus.o_wb_stb),  32'd0);
        check("wr_c2_cyc",  32'(bus.o_wb_cyc),  32'd1);
        check("wr_c2_rv",   32'(bus.rsp_valid), 32'd0);
        step();
        check("wr_c3_rv",   32'(bus.rsp_valid), 32'd1);
        check("wr_c3_data", bus.rsp_data,       32'd0);
        check("wr_c3_err",  32'(bus.rsp_err),   32'd0);
        check("wr_c3_cyc",  32'(bus.o_wb_cyc),  32'd0);
        check("wr_led",     led_reg,            32'h0000_00A5);
        handshake();

        // Read button with three stall cycles, then hold off the response.
        s0 = strobes;
        send(1'b0, BUTTON_ADDR, 32'h0);
        bus.i_wb_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("rd_stall_stb",  32'(bus.o_wb_stb), 32'd1);
            check("rd_stall_addr", bus.o_wb_addr,     BUTTON_ADDR);
            step();
        end
        bus.i_wb_stall = 1'b0;
        check("rd_c4_stb",  32'(bus.o_wb_stb), 32'd1);
        check("rd_c4_addr", bus.o_wb_addr,     BUTTON_ADDR);
        step();
        check("rd_c5_stb",  32'(bus.o_wb_stb), 32'd0);
        check("rd_c5_cyc",  32'(bus.o_wb_cyc), 32'd1);
        step();
        check("rd_strobes", 32'(strobes - s0), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("rd_hold_rv",   32'(bus.rsp_valid), 32'd1);
            check("rd_hold_data", bus.rsp_data,       BTN_VAL);
            check("rd_hold_rdy",  32'(bus.cmd_ready), 32'd0);
            step();
        end
        handshake();

        // Misaligned command never reaches the bus.
        send(1'b0, 32'h3000_0002, 32'h0);
        check("mis_cyc",  32'(bus.o_wb_cyc),  32'd0);
        check("mis_rv",   32'(bus.rsp_valid), 32'd1);
        check("mis_err",  32'(bus.rsp_err),   32'd1);
        check("mis_data", bus.rsp_data,       32'd0);
        step();
        check("mis_cyc2", 32'(bus.o_wb_cyc),  32'd0);
        handshake();

        // Combinational ack in the strobe cycle.
        comb_mode = 1'b1;
        send(1'b0, BUTTON_ADDR, 32'h0);
        check("cmb_c1_cyc", 32'(bus.o_wb_cyc), 32'd1);
        step();
        comb_mode = 1'b0;
        check("cmb_rv",   32'(bus.rsp_valid), 32'd1);
        check("cmb_data", bus.rsp_data,       BTN_VAL);
        check("cmb_cyc",  32'(bus.o_wb_cyc),  32'd0);
        handshake();

        // Reset asserted during WAIT.
        noack_mode = 1'b1;
        send(1'b1, LED_ADDR, 32'h0000_003C);
        step();
        step();
        check("rw_wait_cyc", 32'(bus.o_wb_cyc), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rw_async_cyc", 32'(bus.o_wb_cyc), 32'd0);
        check("rw_async_stb", 32'(bus.o_wb_stb), 32'd0);
        step();
        reset = 1'b0;
        noack_mode = 1'b0;
        repeat (3) step();
        check("rw_rv",  32'(bus.rsp_valid), 32'd0);
        check("rw_rdy", 32'(bus.cmd_ready), 32'd1);

        // Stray ack while idle.
        force_ack = 1'b1;
        step();
        force_ack = 1'b0;
        step();
        check("stray_rv",  32'(bus.rsp_valid), 32'd0);
        check("stray_cyc", 32'(bus.o_wb_cyc),  32'd0);
        check("stray_rdy", 32'(bus.cmd_ready), 32'd1);

        // Normal read after reset.
        send(1'b0, BUTTON_ADDR, 32'h0);
        step();
        step();
        check("post_rv",   32'(bus.rsp_valid), 32'd1);
        check("post_data", bus.rsp_data,       BTN_VAL);
        check("post_err",  32'(bus.rsp_err),   32'd0);
        handshake();

`ifdef WB_TIMEOUT_EN
        // Responder never acks: abort after four WAIT cycles.
        noack_mode = 1'b1;
        send(1'b0, BUTTON_ADDR, 32'h0);
        repeat (4) step();
        check("to_c5_cyc", 32'(bus.o_wb_cyc),  32'd1);
        check("to_c5_rv",  32'(bus.rsp_valid), 32'd0);
        step();
        check("to_cyc",  32'(bus.o_wb_cyc),  32'd0);
        check("to_rv",   32'(bus.rsp_valid), 32'd1);
        check("to_err",  32'(bus.rsp_err),   32'd1);
        check("to_data", bus.rsp_data,       32'd0);
        handshake();

        // Ack on the expiry cycle wins.
        send(1'b0, BUTTON_ADDR, 32'h0);
        repeat (4) step();
        force_ack = 1'b1;
        step();
        force_ack = 1'b0;
        noack_mode = 1'b0;
        check("toa_rv",   32'(bus.rsp_valid), 32'd1);
        check("toa_err",  32'(bus.rsp_err),   32'd0);
        check("toa_data", bus.rsp_data,       BTN_VAL);
        handshake();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
